reg_file_mp: RTL and testbench

Multi-port register file for the 16-bit pipelined processor. It provides a parametrised number of registered read ports and two write ports with fixed priority. Same-cycle write-to-read bypass lets the decode stage see write-back data without a separate forwarding mux. A per-register busy scoreboard records outstanding writes so the hazard unit can stall on RAW dependencies.

---
 rtl/reg_file_mp.sv | 98 +++++++++
 tb/tb_reg_file_mp.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file for the 16-bit pipelined processor.
// Two prioritised write ports (port 1 wins), NRD registered read ports with
// full write-through bypass, and a per-register busy scoreboard.
// Optional feature macro: REG_FILE_MP_ZERO_REG_EN (register 0 hardwired to 0,
// never busy, writes to it discarded and not bypassed).
module reg_file_mp #(
  parameter int DEPTH = 8,
  parameter int ADDR  = 3,
  parameter int WIDTH = 16,
  parameter int NRD   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             w_en,
  input  logic [2*ADDR-1:0]      w_addr,
  input  logic [2*WIDTH-1:0]     w_data,
  input  logic [NRD-1:0]         r_en,
  input  logic [NRD*ADDR-1:0]    r_addr,
  output logic [NRD*WIDTH-1:0]   r_data,
  output logic [NRD-1:0]         r_busy,
  input  logic                   sb_set,
  input  logic [ADDR-1:0]        sb_addr,
  output logic [DEPTH-1:0]       busy_vec
);

  logic [WIDTH-1:0] rf     [DEPTH];
  logic [WIDTH-1:0] wr_val [DEPTH];
  logic [DEPTH-1:0] wr_hit;
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic [NRD*WIDTH-1:0] rd_val;
  logic [NRD-1:0]       rd_busy;

  // Per-register write decode and next busy state. Out-of-range addresses
  // never match any register, so they are ignored naturally. A clear comes
  // from either enabled port, even when its data loses on priority.
  always_comb begin
    wr_hit   = '0;
    busy_nxt = '0;
    for (int unsigned a = 0; a < DEPTH; a++) begin
      logic hit1;
      logic hit0;
      logic set;
      hit1 = w_en[1] && (w_addr[ADDR +: ADDR] == ADDR'(a));
      hit0 = w_en[0] && (w_addr[0 +: ADDR] == ADDR'(a));
      set  = sb_set && (sb_addr == ADDR'(a));
      wr_hit[a]   = hit1 | hit0;
      wr_val[a]   = hit1 ? w_data[WIDTH +: WIDTH] : w_data[0 +: WIDTH];
      busy_nxt[a] = set | (busy[a] & ~(hit1 | hit0));
    end
`ifdef REG_FILE_MP_ZERO_REG_EN
    wr_hit[0]   = 1'b0;
    busy_nxt[0] = 1'b0;
`endif
  end

  // Read mux: the bypass uses the priority-resolved write of the addressed
  // register, so bypass, zero-register and range handling all follow from
  // the same decode as the array update.
  always_comb begin
    rd_val  = '0;
    rd_busy = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      if (r_en[i]) begin
        for (int unsigned a = 0; a < DEPTH; a++) begin
          if (r_addr[i*ADDR +: ADDR] == ADDR'(a)) begin
            rd_val[i*WIDTH +: WIDTH] = wr_hit[a] ? wr_val[a] : rf[a];
            rd_busy[i]               = busy_nxt[a];
          end
        end
      end
    end
  end

  // State update: register array, busy scoreboard and registered read outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned a = 0; a < DEPTH; a++) begin
        rf[a] <= '0;
      end
      busy   <= '0;
      r_data <= '0;
      r_busy <= '0;
    end else begin
      for (int unsigned a = 0; a < DEPTH; a++) begin
        if (wr_hit[a]) begin
          rf[a] <= wr_val[a];
        end
      end
      busy   <= busy_nxt;
      r_data <= rd_val;
      r_busy <= rd_busy;
    end
  end

  assign busy_vec = busy;

endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;

  localparam int DEPTH = 6;
  localparam int ADDR  = 3;
  localparam int WIDTH = 16;
  localparam int NRD   = 3;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [1:0]           w_en = '0;
  logic [2*ADDR-1:0]    w_addr = '0;
  logic [2*WIDTH-1:0]   w_data = '0;
  logic [NRD-1:0]       r_en = '0;
  logic [NRD*ADDR-1:0]  r_addr = '0;
  logic [NRD*WIDTH-1:0] r_data;
  logic [NRD-1:0]       r_busy;
  logic                 sb_set = 1'b0;
  logic [ADDR-1:0]      sb_addr = '0;
  logic [DEPTH-1:0]     busy_vec;

  reg_file_mp #(.DEPTH(DEPTH), .ADDR(ADDR), .WIDTH(WIDTH), .NRD(NRD)) dut (
    .clk(clk), .rst(rst), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .r_en(r_en), .r_addr(r_addr), .r_data(r_data), .r_busy(r_busy),
    .sb_set(sb_set), .sb_addr(sb_addr), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          kind;
    int          port;
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t it;
  int checks = 0;
  int errors = 0;

  always @(negedge clk) begin
    logic [15:0] act;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      it = sb.pop_front();
      case (it.kind)
        0:       act = r_data[it.port*WIDTH +: WIDTH];
        1:       act = {15'd0, r_busy[it.port]};
        default: act = {10'd0, busy_vec};
      endcase
      checks++;
      if (act !== it.val) begin
        errors++;
        $display("FAIL %s (cycle %0d): got %h expected %h", it.name, cyc, act, it.val);
      end
    end
  end

  task automatic push(int due, int kind, int port, logic [15:0] val, string name);
    exp_t e;
    e.due = due; e.kind = kind; e.port = port; e.val = val; e.name = name;
    sb.push_back(e);
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
    w_en = '0; w_addr = '0; w_data = '0;
    r_en = '0; r_addr = '0; sb_set = 1'b0; sb_addr = '0;
  endtask

  task automatic wr(int k, int a, logic [15:0] d);
    w_en[k] = 1'b1;
    w_addr[k*ADDR +: ADDR] = ADDR'(a);
    w_data[k*WIDTH +: WIDTH] = d;
  endtask

  task automatic rd(int i, int a);
    r_en[i] = 1'b1;
    r_addr[i*ADDR +: ADDR] = ADDR'(a);
  endtask

  task automatic setb(int a);
    sb_set = 1'b1;
    sb_addr = ADDR'(a);
  endtask

  task automatic exp_rd(int i, logic [15:0] d, logic b, string n);
    push(cyc + 1, 0, i, d, {n, "_data"});
    push(cyc + 1, 1, i, {15'd0, b}, {n, "_busy"});
  endtask

  task automatic exp_bv(logic [5:0] v, string n);
    push(cyc + 1, 2, 0, {10'd0, v}, {n, "_busy_vec"});
  endtask

  initial begin
    next_cycle();
    wr(0, 1, 16'h9999); setb(1); rd(0, 1); rd(1, 1); rd(2, 0);
    exp_rd(0, 16'h0, 1'b0, "rst_p0"); exp_rd(1, 16'h0, 1'b0, "rst_p1");
    exp_rd(2, 16'h0, 1'b0, "rst_p2"); exp_bv(6'h00, "rst");
    next_cycle(); rst = 1'b0; exp_bv(6'h00, "rel");
    next_cycle(); wr(0, 3, 16'h1234);
    next_cycle(); rd(0, 3); setb(3);
    exp_rd(0, 16'h1234, 1'b1, "pre3"); exp_bv(6'h08, "pre3");
    next_cycle(); rd(0, 3);
    @(posedge clk); #2; rst = 1'b1;
    push(cyc, 0, 0, 16'h0, "async_data");
    push(cyc, 1, 0, 16'h0, "async_busy");
    push(cyc, 2, 0, 16'h0, "async_busy_vec");
    #1;
    checks++;
    if (r_data !== '0) begin
      errors++;
      $display("FAIL async_now_data: got %h", r_data);
    end
    checks++;
    if (r_busy !== '0) begin
      errors++;
      $display("FAIL async_now_busy: got %b", r_busy);
    end
    checks++;
    if (busy_vec !== '0) begin
      errors++;
      $display("FAIL async_now_busy_vec: got %b", busy_vec);
    end
    next_cycle();
    next_cycle(); rst = 1'b0; rd(0, 3);
    exp_rd(0, 16'h0, 1'b0, "post_rst3"); exp_bv(6'h00, "post_rst");
    next_cycle(); wr(0, 2, 16'hA5A5);
    next_cycle(); rd(0, 2); exp_rd(0, 16'hA5A5, 1'b0, "rd2");
    next_cycle(); r_addr[0 +: ADDR] = 3'd2; exp_rd(0, 16'h0, 1'b0, "rd2_dis");
    next_cycle(); wr(0, 5, 16'h1111); wr(1, 5, 16'h2222); rd(1, 5);
    exp_rd(1, 16'h2222, 1'b0, "prio_byp");
    next_cycle(); rd(1, 5); wr(0, 2, 16'hBEEF); rd(2, 2);
    exp_rd(1, 16'h2222, 1'b0, "prio_later"); exp_rd(2, 16'hBEEF, 1'b0, "byp_p0");
    next_cycle(); setb(4); exp_bv(6'h10, "set4");
    next_cycle(); rd(0, 4); exp_rd(0, 16'h0, 1'b1, "busy4"); exp_bv(6'h10, "busy4");
    next_cycle(); wr(0, 4, 16'h0042); rd(0, 4);
    exp_rd(0, 16'h0042, 1'b0, "clr4"); exp_bv(6'h00, "clr4");
    next_cycle(); setb(4); wr(1, 4, 16'h0043); rd(1, 4);
    exp_rd(1, 16'h0043, 1'b1, "setclr4"); exp_bv(6'h10, "setclr4");
    next_cycle(); wr(0, 1, 16'hDEAD); wr(1, 1, 16'h00FF); rd(0, 1);
    exp_rd(0, 16'h00FF, 1'b0, "wr1_byp");
    next_cycle(); rd(0, 1); rd(1, 1); rd(2, 1);
    exp_rd(0, 16'h00FF, 1'b0, "multi_p0"); exp_rd(1, 16'h00FF, 1'b0, "multi_p1");
    exp_rd(2, 16'h00FF, 1'b0, "multi_p2");
    next_cycle(); wr(0, 7, 16'h7777); setb(7); rd(0, 7); rd(1, 6); rd(2, 4);
    exp_rd(0, 16'h0, 1'b0, "oor7"); exp_rd(1, 16'h0, 1'b0, "oor6");
    exp_rd(2, 16'h0043, 1'b1, "in4"); exp_bv(6'h10, "oor");
    next_cycle(); wr(0, 0, 16'hFFFF); setb(0); rd(0, 0);
`ifdef REG_FILE_MP_ZERO_REG_EN
    exp_rd(0, 16'h0, 1'b0, "zero_byp"); exp_bv(6'h10, "zero");
    next_cycle(); rd(0, 0); exp_rd(0, 16'h0, 1'b0, "zero_rd");
`else
    exp_rd(0, 16'hFFFF, 1'b1, "zero_byp"); exp_bv(6'h11, "zero");
    next_cycle(); rd(0, 0); exp_rd(0, 16'hFFFF, 1'b1, "zero_rd");
`endif
    next_cycle();
    for (int n = 0; n < 20 && sb.size() > 0; n++) @(negedge clk);
    #1;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: never checked (due cycle %0d), expected %h", it.name, it.due, it.val);
    end
    if (errors == 0) $display("PASS");
    else $display("FAIL: %0d errors", errors);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
